// File: rtl/sipo_deserializer_pkg.sv
// sipo_deserializer_pkg: FSM encodings and counter sizing helpers shared by the SIPO receiver
package sipo_deserializer_pkg;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COLLECT = 2'd1;
  localparam logic [1:0] PARITY  = 2'd2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 2);
  endfunction
endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: frame bit counter; i_clr/i_inc control, o_cnt current count, o_tc high when the next i_inc completes the frame (count == TERM-1)
module sipo_bit_counter #(
  parameter int TERM = 4,
  parameter int W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);
  logic [W-1:0] r_cnt;
  assign o_tc  = r_cnt == W'(TERM - 1);
  assign o_cnt = r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= o_tc ? '0 : r_cnt + W'(1);
  end
endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out receiver; din/din_valid/clear in, dout/dout_valid/busy/bit_cnt out (+parity_err when SIPO_PARITY_EN is defined)
module sipo_deserializer
  import sipo_deserializer_pkg::*;
#(
  parameter int N         = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   din,
  input  logic                   din_valid,
  input  logic                   clear,
  output logic [N-1:0]           dout,
  output logic                   dout_valid,
  output logic                   busy,
  output logic [$clog2(N+1)-1:0] bit_cnt
`ifdef SIPO_PARITY_EN
  ,
  output logic                   parity_err
`endif
);
`ifdef SIPO_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int CNT_W = cnt_w(N);
  localparam int TERM  = PAR_EN ? N + 1 : N;
  logic [1:0]       r_state;
  logic [N-1:0]     r_sreg;
  logic [CNT_W-1:0] w_cnt;
  logic             w_tc;
  logic             w_inc;
  logic             w_done;
  logic             w_last_data;
  logic             w_shift_en;
  logic [N-1:0]     w_shifted;
  assign w_inc       = din_valid & ~clear;
  assign w_done      = w_inc & w_tc;
  assign w_last_data = w_cnt == CNT_W'(N - 1);
  // the parity bit is not part of the word, so it never enters the shift register
  assign w_shift_en  = w_inc & (r_state != PARITY);
  assign w_shifted   = MSB_FIRST ? {r_sreg[N-2:0], din} : {din, r_sreg[N-1:1]};
  assign busy        = r_state != IDLE;
  assign bit_cnt     = w_cnt[$clog2(N+1)-1:0];
  sipo_bit_counter #(.TERM(TERM), .W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_inc),
    .i_clr (clear),
    .o_cnt (w_cnt),
    .o_tc  (w_tc)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else if (clear) r_state <= IDLE;
    else if (din_valid) r_state <= w_tc ? IDLE : (PAR_EN && w_last_data) ? PARITY : COLLECT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sreg <= '0;
    else if (clear) r_sreg <= '0;
    else if (w_shift_en) r_sreg <= w_shifted;
  end
  // with parity the word is already complete in r_sreg when the parity bit arrives
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      dout_valid <= w_done;
      if (w_done) dout <= PAR_EN ? r_sreg : w_shifted;
    end
  end
`ifdef SIPO_PARITY_EN
  logic r_par;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_par      <= 1'b0;
      parity_err <= 1'b0;
    end else if (clear) r_par <= 1'b0;
    else if (w_done) begin
      r_par      <= 1'b0;
      parity_err <= r_par ^ din;
    end else if (w_inc) r_par <= r_par ^ din;
  end
`endif
endmodule

// File: tb/tb_sipo_deserializer.sv
// tb_sipo_deserializer: directed self-checking bench for sipo_deserializer (MSB-first and LSB-first instances)
module tb_sipo_deserializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] m_dout, l_dout;
  logic       m_dv, l_dv, m_busy, l_busy;
  logic [2:0] m_cnt, l_cnt;
  int         n_cmp = 0;
  int         n_err = 0;
`ifdef SIPO_PARITY_EN
  logic       m_perr, l_perr;
`endif
  always #5 clk = ~clk;
  sipo_deserializer #(.N(4), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(m_dout), .dout_valid(m_dv), .busy(m_busy), .bit_cnt(m_cnt)
`ifdef SIPO_PARITY_EN
    , .parity_err(m_perr)
`endif
  );
  sipo_deserializer #(.N(4), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(l_dout), .dout_valid(l_dv), .busy(l_busy), .bit_cnt(l_cnt)
`ifdef SIPO_PARITY_EN
    , .parity_err(l_perr)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step(input logic d, input logic v, input logic c);
    @(negedge clk);
    din = d;
    din_valid = v;
    clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_chk(input string tag);
    chk({tag, " m_dout"}, 32'(m_dout), 32'h0);
    chk({tag, " m_dv"}, 32'(m_dv), 32'h0);
    chk({tag, " m_busy"}, 32'(m_busy), 32'h0);
    chk({tag, " m_cnt"}, 32'(m_cnt), 32'h0);
  endtask
  // sends n bits, bits[n-1] first; checks busy/count/valid on every edge before the last
  task automatic send(input logic [7:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      step(bits[n-1-i], 1'b1, 1'b0);
      if (i < n - 1) begin
        chk("mid busy", 32'(m_busy), 32'h1);
        chk("mid cnt", 32'(m_cnt), 32'(i + 1));
        chk("mid dv", 32'(m_dv), 32'h0);
      end
    end
  endtask
  task automatic done_chk(input string tag, input logic [3:0] m_exp, input logic [3:0] l_exp);
    chk({tag, " m_dv"}, 32'(m_dv), 32'h1);
    chk({tag, " l_dv"}, 32'(l_dv), 32'h1);
    chk({tag, " m_dout"}, 32'(m_dout), 32'(m_exp));
    chk({tag, " l_dout"}, 32'(l_dout), 32'(l_exp));
    chk({tag, " cnt0"}, 32'(m_cnt), 32'h0);
    chk({tag, " busy0"}, 32'(m_busy), 32'h0);
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      din = ~din;
      din_valid = ~din_valid;
      #1 idle_chk("reset");
    end
    @(negedge clk);
    rst = 1'b0;
    din_valid = 1'b0;
`ifndef SIPO_PARITY_EN
    send(8'b0110, 4);
    done_chk("single", 4'b0110, 4'b0110);
    step(1'b0, 1'b0, 1'b0);
    chk("single dv drop", 32'(m_dv), 32'h0);
    send(8'b0110, 4);
    done_chk("b2b w1", 4'b0110, 4'b0110);
    send(8'b0111, 4);
    done_chk("b2b w2", 4'b0111, 4'b1110);
    step(1'b0, 1'b0, 1'b0);
    chk("b2b dv drop", 32'(l_dv), 32'h0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("gap cnt", 32'(m_cnt), 32'h2);
      chk("gap busy", 32'(m_busy), 32'h1);
      chk("gap dv", 32'(m_dv), 32'h0);
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    done_chk("gap", 4'b1011, 4'b1101);
    send(8'b111, 3);
    step(1'b0, 1'b1, 1'b1);
    chk("abort cnt", 32'(m_cnt), 32'h0);
    chk("abort busy", 32'(m_busy), 32'h0);
    chk("abort dv", 32'(m_dv), 32'h0);
    chk("abort hold", 32'(m_dout), 32'hb);
    send(8'b100, 3);
    chk("abort hold2", 32'(m_dout), 32'hb);
    step(1'b1, 1'b1, 1'b0);
    done_chk("abort", 4'b1001, 4'b1001);
    send(8'b010, 3);
    step(1'b1, 1'b1, 1'b1);
    chk("clr on done dv", 32'(m_dv), 32'h0);
    chk("clr on done dout", 32'(m_dout), 32'h9);
    chk("clr on done cnt", 32'(m_cnt), 32'h0);
`else
    send(8'b01100, 5);
    done_chk("par ok", 4'b0110, 4'b0110);
    chk("par ok perr", 32'(m_perr), 32'h0);
    send(8'b01110, 5);
    done_chk("par bad", 4'b0111, 4'b1110);
    chk("par bad perr", 32'(m_perr), 32'h1);
    chk("par bad lperr", 32'(l_perr), 32'h1);
`endif
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 idle_chk("midrst");
    @(negedge clk);
    rst = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
